// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
//   Shared definitions for the shift-register sequencer:
//     - 3-bit operation codes driven on the shift register's sel input
//     - sequencer FSM state encoding
//     - next_q(): the register's one-cycle update rule, used by the shadow
//       model so that exp_out tracks the real register bit for bit
// -----------------------------------------------------------------------------
package shift_pkg;

    // Width of the shift register that next_q() models.
    localparam int DATA_W = 4;

    // Operation / sel encoding of the multi-mode shift register.
    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SRL  = 3'b010;
    localparam logic [2:0] OP_SLL  = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;
    localparam logic [2:0] OP_SRA  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_STEP = 2'b10,
        ST_DONE = 2'b11
    } seq_state_t;

    // Contents of the register after one clock with the given sel and d_in.
    function automatic logic [DATA_W-1:0] next_q(
        input logic [DATA_W-1:0] q,
        input logic [2:0]        op,
        input logic [DATA_W-1:0] d
    );
        logic [DATA_W-1:0] r;
        r = q;
        case (op)
            OP_HOLD: r = q;
            OP_LOAD: r = d;
            OP_SRL:  r = {1'b0, q[DATA_W-1:1]};
            OP_SLL:  r = {q[DATA_W-2:0], 1'b0};
            OP_ROR:  r = {q[0], q[DATA_W-1:1]};
            OP_ROL:  r = {q[DATA_W-2:0], q[DATA_W-1]};
            OP_SRA:  r = {q[DATA_W-1], q[DATA_W-1:1]};
            OP_CLR:  r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/shift_shadow.sv
// -----------------------------------------------------------------------------
// shift_shadow
//   Behavioural twin of the 4-bit multi-mode shift register. It sees the same
//   sel/d_in the real register sees and applies the same update on the same
//   edge, so q always equals the real register's output. Usable on its own as
//   a reference model.
//
//   WIDTH must equal shift_pkg::DATA_W, the width next_q() is written for.
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous, active-low; clears q
//   sel    in   3-bit mode select (shift_pkg OP_* codes)
//   d_in   in   parallel load data
//   q      out  modelled register contents
// -----------------------------------------------------------------------------
module shift_shadow
    import shift_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q
);

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the values from before the edge, exactly like hardware.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= '0;
        end else begin
            q <= next_q(q, sel, d_in);
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
//   Command-driven controller for the 4-bit multi-mode shift register. One
//   command is accepted at a time (cmd_valid && cmd_ready). A command may
//   preload cmd_data, then applies cmd_op for its effective step count, then
//   pulses done for one cycle. A shadow model produces exp_out, the contents
//   the downstream register is expected to hold.
//
//   Every output comes directly from a flop: the combinational block computes
//   the values for the *next* cycle and the register block captures them.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-low; aborts any command, no done
//   cmd_valid  in   command present
//   cmd_ready  out  command can be accepted (high only in IDLE)
//   cmd_load   in   preload cmd_data before the operation
//   cmd_op     in   operation code (shift_pkg OP_*)
//   cmd_data   in   preload value
//   cmd_count  in   number of operation steps
//   sel        out  mode select to the shift register
//   d_in       out  parallel data to the shift register (latched cmd_data)
//   busy       out  command in progress
//   done       out  one-cycle pulse when a command completes
//   exp_out    out  shadow of the expected register contents
// -----------------------------------------------------------------------------
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH   = DATA_W,
    parameter int COUNT_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_load,
    input  logic [2:0]         cmd_op,
    input  logic [WIDTH-1:0]   cmd_data,
    input  logic [COUNT_W-1:0] cmd_count,
    output logic [2:0]         sel,
    output logic [WIDTH-1:0]   d_in,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   exp_out
);

    // Number of STEP cycles a command really needs: LOAD has no steps of its
    // own, and repeated clears are indistinguishable from a single clear.
    function automatic logic [COUNT_W-1:0] eff_steps(
        input logic [2:0]         op,
        input logic [COUNT_W-1:0] count
    );
        logic [COUNT_W-1:0] n;
        n = count;
        if (op == OP_LOAD) begin
            n = '0;
        end else if (op == OP_CLR) begin
            n = (count != '0) ? COUNT_W'(1) : '0;
        end
        return n;
    endfunction

    seq_state_t         state,   state_nx;
    logic [2:0]         op_q,    op_nx;
    logic [COUNT_W-1:0] cnt_q,   cnt_nx;
    logic [2:0]         sel_nx;
    logic [WIDTH-1:0]   d_in_nx;
    logic               busy_nx;
    logic               done_nx;
    logic               ready_nx;

    logic               accept;
    logic [COUNT_W-1:0] cmd_steps;

    assign accept = cmd_valid && cmd_ready;

    always_comb begin
        cmd_steps = eff_steps(cmd_op, cmd_count);
    end

    // Next-state and next-output logic. cnt_q holds the steps still to be
    // issued, counting the one in the current STEP cycle.
    always_comb begin
        // NOTE: every signal gets a default before the case so no branch can
        // leave one unassigned and infer a latch.
        state_nx = state;
        op_nx    = op_q;
        cnt_nx   = cnt_q;
        sel_nx   = OP_HOLD;
        d_in_nx  = d_in;
        busy_nx  = busy;
        done_nx  = 1'b0;
        ready_nx = cmd_ready;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    op_nx    = cmd_op;
                    cnt_nx   = cmd_steps;
                    d_in_nx  = cmd_data;
                    busy_nx  = 1'b1;
                    ready_nx = 1'b0;
                    if (cmd_load || (cmd_op == OP_LOAD)) begin
                        state_nx = ST_LOAD;
                        sel_nx   = OP_LOAD;
                    end else if (cmd_steps != '0) begin
                        state_nx = ST_STEP;
                        sel_nx   = cmd_op;
                    end else begin
                        state_nx = ST_DONE;
                        done_nx  = 1'b1;
                    end
                end
            end

            ST_LOAD: begin
                if (cnt_q != '0) begin
                    state_nx = ST_STEP;
                    sel_nx   = op_q;
                end else begin
                    state_nx = ST_DONE;
                    done_nx  = 1'b1;
                end
            end

            ST_STEP: begin
                // cnt_q is never zero here; one means this is the last step.
                if (cnt_q == COUNT_W'(1)) begin
                    state_nx = ST_DONE;
                    done_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt_q - COUNT_W'(1);
                    sel_nx = op_q;
                end
            end

            ST_DONE: begin
                state_nx = ST_IDLE;
                busy_nx  = 1'b0;
                ready_nx = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            op_q      <= OP_HOLD;
            cnt_q     <= '0;
            sel       <= OP_HOLD;
            d_in      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            state     <= state_nx;
            op_q      <= op_nx;
            cnt_q     <= cnt_nx;
            sel       <= sel_nx;
            d_in      <= d_in_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            cmd_ready <= ready_nx;
        end
    end

    // The shadow consumes the registered sel/d_in, so it changes on the same
    // edge the real register does and exp_out lines up with its output.
    shift_shadow #(
        .WIDTH (WIDTH)
    ) u_shadow (
        .clk   (clk),
        .reset (reset),
        .sel   (sel),
        .d_in  (d_in),
        .q     (exp_out)
    );

endmodule
